sdram_ex_pattern_lfsr: RTL and testbench

Parametrised test-pattern generator and checker for the SDRAM example test harness, generalising the fixed 8-bit LFSR to any width and polynomial, with selectable pattern modes. A generator state register drives write data. An independent checker state register reproduces the same sequence to compare read-back data, and keeps error statistics. Sits between the harness sequencer and the SDRAM controller's Avalon data paths.

---
 rtl/sdram_ex_pattern_lfsr.sv | 146 ++++++++++++++
 tb/tb_sdram_ex_pattern_lfsr.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_ex_pattern_lfsr.sv
// -----------------------------------------------------------------------------
// sdram_ex_pattern_lfsr
//
// Test-pattern generator and checker for the SDRAM example harness.
// The generator state drives write data. An independent checker state
// replays the same sequence to compare read-back words, and it keeps error
// statistics. The step function is chosen by 'mode': a Galois LFSR of any
// width and polynomial, increment, walking-one, or alternate-invert.
//
// Ports
//   clk, reset_n    clock, asynchronous active-low reset
//   enable          0 holds both states at SEED
//   mode            00 LFSR, 01 increment, 10 walking-one, 11 alternate-invert
//   load, ldata     load ldata into both generator and checker
//   gen_adv, pause  advance the generator unless paused
//   gen_data        generator state (registered)
//   chk_valid       chk_data is valid; compare it and advance the checker
//   chk_data        read-back word
//   clr_err         clear the error statistics
//   chk_exp         checker expected word (registered)
//   err_flag        sticky mismatch flag
//   err_count       saturating mismatch count
//   first_err_exp   expected word at the first mismatch
//   first_err_got   received word at the first mismatch
// -----------------------------------------------------------------------------
module sdram_ex_pattern_lfsr #(
    parameter int          WIDTH = 32,
    parameter logic [63:0] POLY  = 64'h0000_0000_0040_0007,
    parameter logic [63:0] SEED  = 64'h0000_0000_0000_0020,
    parameter int          ERRW  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] ldata,
    input  logic             gen_adv,
    input  logic             pause,
    output logic [WIDTH-1:0] gen_data,
    input  logic             chk_valid,
    input  logic [WIDTH-1:0] chk_data,
    input  logic             clr_err,
    output logic [WIDTH-1:0] chk_exp,
    output logic             err_flag,
    output logic [ERRW-1:0]  err_count,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got
);

    typedef enum logic [1:0] {
        MODE_LFSR = 2'b00,
        MODE_INC  = 2'b01,
        MODE_WALK = 2'b10,
        MODE_INV  = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] POLY_W  = POLY[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W  = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [ERRW-1:0]  ERR_MAX = '1;

    // One step of the selected pattern. The all-zero state is a fixed point
    // for both LFSR and rotate, so both escape to 1 instead of locking up.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s,
                                              input mode_e            m);
        logic [WIDTH-1:0] r;
        r = s;
        case (m)
            MODE_LFSR: r = (s == '0) ? ONE_W
                         : ({s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY_W : '0));
            MODE_INC:  r = s + ONE_W;
            MODE_WALK: r = (s == '0) ? ONE_W : {s[WIDTH-2:0], s[WIDTH-1]};
            MODE_INV:  r = ~s;
            default:   r = s;
        endcase
        return r;
    endfunction

    mode_e            cur_mode;
    logic [WIDTH-1:0] gen_next;
    logic [WIDTH-1:0] chk_next;
    logic             mismatch;

    assign cur_mode = mode_e'(mode);

    // NOTE: every signal driven here gets a default first, so no path
    // through the if-chain can leave it unassigned and infer a latch.
    always_comb begin
        gen_next = gen_data;
        if (!enable)
            gen_next = SEED_W;
        else if (load)
            gen_next = ldata;
        else if (gen_adv && !pause)
            gen_next = step(gen_data, cur_mode);

        chk_next = chk_exp;
        if (!enable)
            chk_next = SEED_W;
        else if (load)
            chk_next = ldata;
        else if (chk_valid)
            chk_next = step(chk_exp, cur_mode);

        // A load cycle only loads, so it is never compared.
        mismatch = enable && !load && chk_valid && (chk_data != chk_exp);
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_data <= SEED_W;
            chk_exp  <= SEED_W;
        end else begin
            gen_data <= gen_next;
            chk_exp  <= chk_next;
        end
    end

    // Statistics. clr_err beats a simultaneous mismatch, and the mismatch is
    // dropped. With enable low, mismatch is forced low, so the statistics hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_flag      <= 1'b0;
            err_count     <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (clr_err) begin
            err_flag      <= 1'b0;
            err_count     <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (mismatch) begin
            err_flag <= 1'b1;
            if (err_count != ERR_MAX)
                err_count <= err_count + ERRW'(1);
            if (!err_flag) begin
                first_err_exp <= chk_exp;
                first_err_got <= chk_data;
            end
        end
    end

endmodule

// File: tb/tb_sdram_ex_pattern_lfsr.sv
// -----------------------------------------------------------------------------
// Testbench for sdram_ex_pattern_lfsr (WIDTH=8, POLY=0x1D, SEED=0x20,
// ERRW=4). Every stimulus cycle pushes its expected post-edge outputs to a
// scoreboard queue. The queue entries come from a reference model of the
// pattern rules. Each test pops the entries and compares them against the
// DUT outputs at the falling edge.
// -----------------------------------------------------------------------------
module tb_sdram_ex_pattern_lfsr;

    localparam int W  = 8;
    localparam int EW = 4;
    localparam logic [7:0] SEED8 = 8'h20;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [1:0]    mode;
    logic          load;
    logic [W-1:0]  ldata;
    logic          gen_adv;
    logic          pause;
    logic [W-1:0]  gen_data;
    logic          chk_valid;
    logic [W-1:0]  chk_data;
    logic          clr_err;
    logic [W-1:0]  chk_exp;
    logic          err_flag;
    logic [EW-1:0] err_count;
    logic [W-1:0]  first_err_exp;
    logic [W-1:0]  first_err_got;

    always #5 clk = ~clk;

    sdram_ex_pattern_lfsr #(
        .WIDTH(W),
        .POLY (64'h1D),
        .SEED (64'h20),
        .ERRW (EW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .mode         (mode),
        .load         (load),
        .ldata        (ldata),
        .gen_adv      (gen_adv),
        .pause        (pause),
        .gen_data     (gen_data),
        .chk_valid    (chk_valid),
        .chk_data     (chk_data),
        .clr_err      (clr_err),
        .chk_exp      (chk_exp),
        .err_flag     (err_flag),
        .err_count    (err_count),
        .first_err_exp(first_err_exp),
        .first_err_got(first_err_got)
    );

    typedef struct packed {
        logic [7:0] gen;
        logic [7:0] chk;
        logic       flag;
        logic [3:0] cnt;
        logic [7:0] fexp;
        logic [7:0] fgot;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [7:0] m_gen  = SEED8;
    logic [7:0] m_chk  = SEED8;
    logic       m_flag = 1'b0;
    logic [3:0] m_cnt  = 4'd0;
    logic [7:0] m_fexp = 8'h00;
    logic [7:0] m_fgot = 8'h00;

    function automatic logic [7:0] model_next(input logic [7:0] s, input logic [1:0] m);
        logic [7:0] r;
        r = s;
        case (m)
            2'b00: r = (s == 8'h00) ? 8'h01 : ({s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00));
            2'b01: r = s + 8'h01;
            2'b10: r = (s == 8'h00) ? 8'h01 : {s[6:0], s[7]};
            default: r = ~s;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_gen = SEED8; m_chk = SEED8; m_flag = 1'b0;
        m_cnt = 4'd0; m_fexp = 8'h00; m_fgot = 8'h00;
        sb.delete();
    endtask

    // Apply one cycle of stimulus. Push the expected outputs after the edge,
    // then advance to the next falling edge.
    task automatic drive(input logic en, input logic [1:0] md, input logic ld,
                         input logic [7:0] ldat, input logic adv, input logic ps,
                         input logic cv, input logic [7:0] cd, input logic clr);
        logic mm;
        exp_t e;
        enable = en; mode = md; load = ld; ldata = ldat; gen_adv = adv;
        pause = ps; chk_valid = cv; chk_data = cd; clr_err = clr;
        mm = en && !ld && cv && (cd != m_chk);
        if (clr) begin
            m_flag = 1'b0; m_cnt = 4'd0; m_fexp = 8'h00; m_fgot = 8'h00;
        end else if (mm) begin
            if (!m_flag) begin
                m_fexp = m_chk;
                m_fgot = cd;
            end
            m_flag = 1'b1;
            if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        end
        if (!en)               m_gen = SEED8;
        else if (ld)           m_gen = ldat;
        else if (adv && !ps)   m_gen = model_next(m_gen, md);
        if (!en)               m_chk = SEED8;
        else if (ld)           m_chk = ldat;
        else if (cv)           m_chk = model_next(m_chk, md);
        e = '{gen: m_gen, chk: m_chk, flag: m_flag, cnt: m_cnt, fexp: m_fexp, fgot: m_fgot};
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic gen_step(input logic [1:0] md);
        drive(1'b1, md, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic load_both(input logic [7:0] v, input logic clr);
        drive(1'b1, 2'b00, 1'b1, v, 1'b0, 1'b0, 1'b0, 8'h00, clr);
    endtask

    task automatic chk_word(input logic [7:0] cd);
        drive(1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, cd, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b0; mode = 2'b00; load = 1'b0; ldata = 8'h00; gen_adv = 1'b0;
        pause = 1'b0; chk_valid = 1'b0; chk_data = 8'h00; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (gen_data !== 8'h20) begin errors++; $display("FAIL reset_gen: got %h want 20", gen_data); end
        checks++; if (chk_exp !== 8'h20) begin errors++; $display("FAIL reset_chk: got %h want 20", chk_exp); end
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b want 0", err_flag); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", err_count); end
        checks++; if (first_err_exp !== 8'h00 || first_err_got !== 8'h00) begin
            errors++; $display("FAIL reset_first: got %h/%h want 00/00", first_err_exp, first_err_got);
        end
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_lfsr_legacy();
        logic [7:0] legacy [4];
        exp_t e;
        legacy = '{8'h40, 8'h80, 8'h1D, 8'h3A};
        for (int i = 0; i < 4; i++) begin
            gen_step(2'b00);
            e = sb.pop_front();
            checks++; if (gen_data !== legacy[i]) begin errors++; $display("FAIL lfsr_legacy%0d: got %h want %h", i, gen_data, legacy[i]); end
        end
        checks++; if (chk_exp !== 8'h20) begin errors++; $display("FAIL chk_independent: got %h want 20", chk_exp); end
        for (int i = 0; i < 251; i++) begin
            gen_step(2'b00);
            e = sb.pop_front();
            checks++; if (gen_data !== e.gen) begin errors++; $display("FAIL lfsr_run%0d: got %h want %h", i, gen_data, e.gen); end
        end
        checks++; if (gen_data !== 8'h20) begin errors++; $display("FAIL lfsr_period: got %h want 20", gen_data); end
    endtask

    task automatic test_pause_load();
        exp_t e;
        drive(1'b1, 2'b00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        e = sb.pop_front();
        checks++; if (gen_data !== 8'h20 || gen_data !== e.gen) begin errors++; $display("FAIL pause_hold: got %h want 20", gen_data); end
        drive(1'b1, 2'b00, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        e = sb.pop_front();
        checks++; if (gen_data !== 8'hA5) begin errors++; $display("FAIL load_gen: got %h want a5", gen_data); end
        checks++; if (chk_exp !== 8'hA5 || chk_exp !== e.chk) begin errors++; $display("FAIL load_chk: got %h want a5", chk_exp); end
    endtask

    task automatic test_modes();
        logic [1:0] md  [5];
        logic [7:0] ld  [5];
        logic [7:0] exv [5];
        exp_t e;
        md  = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
        ld  = '{8'hFF, 8'h80, 8'h00, 8'h5A, 8'h00};
        exv = '{8'h00, 8'h01, 8'h01, 8'hA5, 8'h01};
        for (int i = 0; i < 5; i++) begin
            load_both(ld[i], 1'b0);
            e = sb.pop_front();
            gen_step(md[i]);
            e = sb.pop_front();
            checks++; if (gen_data !== exv[i] || gen_data !== e.gen) begin
                errors++; $display("FAIL mode%0d_step%0d: got %h want %h", md[i], i, gen_data, exv[i]);
            end
            checks++; if (chk_exp !== ld[i]) begin
                errors++; $display("FAIL mode_chk_hold%0d: got %h want %h", i, chk_exp, ld[i]);
            end
        end
    endtask

    task automatic test_clean_loop();
        exp_t e;
        load_both(8'h20, 1'b1);
        e = sb.pop_front();
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, gen_data, 1'b0);
            e = sb.pop_front();
            checks++; if (gen_data !== e.gen || chk_exp !== e.chk) begin
                errors++; $display("FAIL clean_word%0d: got %h/%h want %h/%h", i, gen_data, chk_exp, e.gen, e.chk);
            end
        end
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL clean_flag: got %b want 0", err_flag); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL clean_cnt: got %0d want 0", err_count); end
    endtask

    task automatic test_mismatch();
        exp_t e;
        logic [7:0] cd;
        load_both(8'h20, 1'b1);
        e = sb.pop_front();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                checks++; if (chk_exp !== 8'h1D) begin errors++; $display("FAIL word3_exp: got %h want 1d", chk_exp); end
            end
            cd = (i == 3) ? 8'h1C : (i == 5) ? ~m_chk : m_chk;
            chk_word(cd);
            e = sb.pop_front();
            checks++; if (err_flag !== e.flag || err_count !== e.cnt) begin
                errors++; $display("FAIL mm_word%0d: flag/cnt got %b/%0d want %b/%0d", i, err_flag, err_count, e.flag, e.cnt);
            end
        end
        checks++; if (err_count !== 4'd2) begin errors++; $display("FAIL mm_cnt: got %0d want 2", err_count); end
        checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL mm_flag: got %b want 1", err_flag); end
        checks++; if (first_err_exp !== 8'h1D) begin errors++; $display("FAIL first_exp: got %h want 1d", first_err_exp); end
        checks++; if (first_err_got !== 8'h1C) begin errors++; $display("FAIL first_got: got %h want 1c", first_err_got); end
        // clear together with a mismatch: clear wins, checker still advances
        drive(1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, ~m_chk, 1'b1);
        e = sb.pop_front();
        checks++; if (err_count !== 4'd0 || err_flag !== 1'b0) begin
            errors++; $display("FAIL clr_wins: flag/cnt got %b/%0d want 0/0", err_flag, err_count);
        end
        checks++; if (first_err_exp !== 8'h00 || first_err_got !== 8'h00) begin
            errors++; $display("FAIL clr_first: got %h/%h want 00/00", first_err_exp, first_err_got);
        end
        checks++; if (chk_exp !== e.chk) begin errors++; $display("FAIL clr_chk_adv: got %h want %h", chk_exp, e.chk); end
    endtask

    task automatic test_back_to_back_and_disable();
        exp_t e;
        // generator and checker advance together, with a mismatch on the checker
        drive(1'b1, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, ~m_chk, 1'b0);
        e = sb.pop_front();
        checks++; if (gen_data !== e.gen || chk_exp !== e.chk) begin
            errors++; $display("FAIL both_adv: got %h/%h want %h/%h", gen_data, chk_exp, e.gen, e.chk);
        end
        // disabled: states to SEED, statistics held, no compare
        drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        e = sb.pop_front();
        checks++; if (gen_data !== 8'h20 || chk_exp !== 8'h20) begin
            errors++; $display("FAIL disable_seed: got %h/%h want 20/20", gen_data, chk_exp);
        end
        checks++; if (err_count !== 4'd1 || err_flag !== 1'b1 || err_count !== e.cnt) begin
            errors++; $display("FAIL disable_hold: flag/cnt got %b/%0d want 1/1", err_flag, err_count);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        load_both(8'h20, 1'b1);
        e = sb.pop_front();
        for (int i = 0; i < 20; i++) begin
            chk_word(~m_chk);
            e = sb.pop_front();
            checks++; if (err_count !== e.cnt) begin errors++; $display("FAIL sat_step%0d: got %0d want %0d", i, err_count, e.cnt); end
        end
        checks++; if (err_count !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d want 15", err_count); end
        checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b want 1", err_flag); end
    endtask

    task automatic test_async_reset();
        exp_t e;
        gen_step(2'b00);
        e = sb.pop_front();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (gen_data !== 8'h20 || chk_exp !== 8'h20) begin
            errors++; $display("FAIL areset_state: got %h/%h want 20/20", gen_data, chk_exp);
        end
        checks++; if (err_flag !== 1'b0 || err_count !== 4'd0) begin
            errors++; $display("FAIL areset_stats: flag/cnt got %b/%0d want 0/0", err_flag, err_count);
        end
        checks++; if (first_err_exp !== 8'h00 || first_err_got !== 8'h00) begin
            errors++; $display("FAIL areset_first: got %h/%h want 00/00", first_err_exp, first_err_got);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        gen_step(2'b00);
        e = sb.pop_front();
        checks++; if (gen_data !== 8'h40 || gen_data !== e.gen) begin
            errors++; $display("FAIL areset_resume: got %h want 40", gen_data);
        end
    endtask

    initial begin
        test_reset();
        test_lfsr_legacy();
        test_pause_load();
        test_modes();
        test_clean_loop();
        test_mismatch();
        test_back_to_back_and_disable();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
